// File: rtl/y86_alu_pkg.sv
// Shared types for the Y86 execute-stage ALU: operation and condition encodings,
// the architectural condition-code record and its reset value.
package y86_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_XOR = 2'b10,
    OP_AND = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_LE     = 3'd1,
    COND_L      = 3'd2,
    COND_E      = 3'd3,
    COND_NE     = 3'd4,
    COND_GE     = 3'd5,
    COND_G      = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_cond_eval.sv
// Combinational Y86 branch/cmov condition evaluation against a set of flags.
// Kept standalone so the branch-prediction check can reuse it.
module alu_cond_eval
  import y86_alu_pkg::*;
(
  input  cc_t        cc,
  input  logic [2:0] cond,
  output logic       cnd
);

  logic lt;

  always_comb begin
    lt  = cc.sf ^ cc.of;
    cnd = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: cnd = 1'b1;
      COND_LE:     cnd = lt | cc.zf;
      COND_L:      cnd = lt;
      COND_E:      cnd = cc.zf;
      COND_NE:     cnd = ~cc.zf;
      COND_GE:     cnd = ~lt;
      COND_G:      cnd = ~lt & ~cc.zf;
      COND_NEVER:  cnd = 1'b0;
      default:     cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipelined_alu_cc.sv
// Registered Y86 execute-stage ALU: one result register behind a valid/ready
// handshake, an architectural ZF/SF/OF register, condition evaluation and flush.
module pipelined_alu_cc
  import y86_alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_set_cc,
  input  logic [2:0]       in_cond,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_of,
  output logic             out_cnd,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  localparam int MSB = WIDTH - 1;

  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             of_reg;
  logic             cnd_reg;
  cc_t              cc_reg;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] result_next;
  logic             of_next;
  logic             cnd_next;
  cc_t              cc_next;
  logic             accept;

  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Subtraction reuses the adder as a + ~b + 1; the carry out is dropped.
  assign is_sub = (alu_op_e'(in_op) == OP_SUB);
  assign b_eff  = is_sub ? ~in_b : in_b;
  assign sum    = in_a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};

  always_comb begin
    result_next = sum;
    of_next     = 1'b0;
    case (alu_op_e'(in_op))
      OP_ADD: of_next = (in_a[MSB] == in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      OP_SUB: of_next = (in_a[MSB] != in_b[MSB]) && (sum[MSB] != in_a[MSB]);
      OP_XOR: result_next = in_a ^ in_b;
      OP_AND: result_next = in_a & in_b;
      default: result_next = sum;
    endcase
    cc_next.zf = (result_next == '0);
    cc_next.sf = result_next[MSB];
    cc_next.of = of_next;
  end

  // The condition sees the flags as they stand before this operation's update.
  alu_cond_eval u_cond_eval (
    .cc   (cc_reg),
    .cond (in_cond),
    .cnd  (cnd_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      of_reg        <= 1'b0;
      cnd_reg       <= 1'b0;
      cc_reg        <= CC_RESET;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      result_reg    <= result_next;
      of_reg        <= of_next;
      cnd_reg       <= cnd_next;
      if (in_set_cc) begin
        cc_reg <= cc_next;
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_result = result_reg;
  assign out_of     = of_reg;
  assign out_cnd    = cnd_reg;
  assign cc_zf      = cc_reg.zf;
  assign cc_sf      = cc_reg.sf;
  assign cc_of      = cc_reg.of;

endmodule

// File: tb/tb_pipelined_alu_cc.sv
// Directed bench for pipelined_alu_cc: a streamed vector table plus hand-written
// stall, flush and asynchronous-reset sequences.
module tb_pipelined_alu_cc;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_op;
  logic         in_set_cc;
  logic [2:0]   in_cond;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_of;
  logic         out_cnd;
  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_alu_cc #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_set_cc  (in_set_cc),
    .in_cond    (in_cond),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_of     (out_of),
    .out_cnd    (out_cnd),
    .cc_zf      (cc_zf),
    .cc_sf      (cc_sf),
    .cc_of      (cc_of)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic         set_cc;
    logic [2:0]   cond;
    logic [W-1:0] res;
    logic         of;
    logic         cnd;
    logic         zf;
    logic         sf;
    logic         cof;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] op,
                              logic set_cc, logic [2:0] cond, logic [W-1:0] res,
                              logic of, logic cnd, logic zf, logic sf, logic cof);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.set_cc = set_cc; v.cond = cond;
    v.res = res; v.of = of; v.cnd = cnd; v.zf = zf; v.sf = sf; v.cof = cof;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 2'd0;
    in_set_cc = 1'b0; in_cond = 3'd0; flush = 1'b0;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input logic set_cc, input logic [2:0] cond);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
    in_set_cc = set_cc; in_cond = cond;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    // op: 0 ADD, 1 SUB, 2 XOR, 3 AND; cond: 0 always,1 le,2 l,3 e,4 ne,5 ge,6 g,7 never
    // Flags chain from reset {zf=1,sf=0,of=0} through the table in order.
    vecs[0]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 1'b1, 3'd0, 64'h8000_0000_0000_0000, 1, 1, 0, 1, 1);
    vecs[1]  = mk(64'h5, 64'h5, 2'd1, 1'b1, 3'd3, 64'h0, 0, 0, 1, 0, 0);
    vecs[2]  = mk(64'hF0, 64'hFF, 2'd2, 1'b0, 3'd3, 64'h0F, 0, 1, 1, 0, 0);
    vecs[3]  = mk(64'h3, 64'h7, 2'd1, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 1, 0);
    vecs[4]  = mk(64'hFF, 64'h0F, 2'd3, 1'b0, 3'd6, 64'h0F, 0, 0, 0, 1, 0);
    vecs[5]  = mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'd0, 1'b1, 3'd2, 64'h0, 1, 1, 1, 0, 1);
    vecs[6]  = mk(64'h8000_0000_0000_0000, 64'h1, 2'd1, 1'b1, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 1);
    vecs[7]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 2'd2, 1'b1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0);
    vecs[8]  = mk(64'h1, 64'h2, 2'd0, 1'b0, 3'd7, 64'h3, 0, 0, 0, 1, 0);
    vecs[9]  = mk(64'h7, 64'h3, 2'd1, 1'b1, 3'd6, 64'h4, 0, 0, 0, 0, 0);
    vecs[10] = mk(64'hF0, 64'h0F, 2'd3, 1'b1, 3'd6, 64'h0, 0, 1, 1, 0, 0);
    vecs[11] = mk(64'h0, 64'h0, 2'd0, 1'b0, 3'd5, 64'h0, 0, 1, 1, 0, 0);
    vecs[12] = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 3'd0, 64'h8000_0000_0000_0000, 1, 1, 0, 1, 1);

    do_reset();
    chk("reset out_valid", out_valid, 0);
    chk("reset out_result", out_result, 0);
    chk("reset out_of", out_of, 0);
    chk("reset out_cnd", out_cnd, 0);
    chk("reset zf", cc_zf, 1);
    chk("reset sf", cc_sf, 0);
    chk("reset of", cc_of, 0);
    chk("reset in_ready", in_ready, 1);

    // Full-throughput stream: one vector per cycle, each result the next cycle.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].set_cc, vecs[i].cond);
      step();
      $display("vec %0d: op=%0d cond=%0d result=0x%0h of=%0b cnd=%0b cc=%0b%0b%0b",
               i, vecs[i].op, vecs[i].cond, out_result, out_of, out_cnd, cc_zf, cc_sf, cc_of);
      chk($sformatf("vec%0d valid", i), out_valid, 1);
      chk($sformatf("vec%0d result", i), out_result, vecs[i].res);
      chk($sformatf("vec%0d of", i), out_of, vecs[i].of);
      chk($sformatf("vec%0d cnd", i), out_cnd, vecs[i].cnd);
      chk($sformatf("vec%0d zf", i), cc_zf, vecs[i].zf);
      chk($sformatf("vec%0d sf", i), cc_sf, vecs[i].sf);
      chk($sformatf("vec%0d ccof", i), cc_of, vecs[i].cof);
    end
    idle();
    step();
    chk("stream drain valid", out_valid, 0);

    // Stall: XOR held while downstream is blocked; the next op waits.
    do_reset();
    out_ready = 1'b0;
    drive(64'hF0, 64'hFF, 2'd2, 1'b0, 3'd0);
    step();
    chk("stall first valid", out_valid, 1);
    chk("stall first result", out_result, 64'h0F);
    drive(64'h1, 64'h1, 2'd0, 1'b1, 3'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      $display("stall cycle %0d: valid=%0b result=0x%0h in_ready=%0b", c, out_valid, out_result, in_ready);
      chk("stall hold valid", out_valid, 1);
      chk("stall hold result", out_result, 64'h0F);
      chk("stall in_ready", in_ready, 0);
      chk("stall no cc zf", cc_zf, 1);
    end
    out_ready = 1'b1;
    #1;
    chk("stall release in_ready", in_ready, 1);
    step();
    chk("stall next valid", out_valid, 1);
    chk("stall next result", out_result, 64'h2);
    chk("stall next zf", cc_zf, 0);
    idle();
    step();
    chk("stall drain valid", out_valid, 0);
    chk("stall drain result held", out_result, 64'h2);

    // Flush: a held result and an offered ADD with set_cc are both squashed.
    do_reset();
    out_ready = 1'b0;
    drive(64'h1, 64'h1, 2'd0, 1'b1, 3'd0);
    step();
    chk("flush setup valid", out_valid, 1);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'd0, 1'b1, 3'd0);
    step();
    $display("flush: valid=%0b result=0x%0h cc=%0b%0b%0b", out_valid, out_result, cc_zf, cc_sf, cc_of);
    chk("flush valid", out_valid, 0);
    chk("flush zf", cc_zf, 0);
    chk("flush sf", cc_sf, 0);
    chk("flush of", cc_of, 0);
    idle();
    step();
    chk("flush after valid", out_valid, 0);
    chk("flush after result", out_result, 64'h2);

    // Asynchronous reset in the middle of a stalled operation.
    out_ready = 1'b0;
    drive(64'h3, 64'h7, 2'd1, 1'b1, 3'd0);
    step();
    chk("arst setup valid", out_valid, 1);
    chk("arst setup sf", cc_sf, 1);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset: valid=%0b result=0x%0h cnd=%0b zf=%0b", out_valid, out_result, out_cnd, cc_zf);
    chk("arst valid", out_valid, 0);
    chk("arst result", out_result, 0);
    chk("arst cnd", out_cnd, 0);
    chk("arst zf", cc_zf, 1);
    chk("arst sf", cc_sf, 0);
    chk("arst in_ready", in_ready, 1);
    idle();
    step();
    rst = 1'b0;
    step();
    chk("arst after valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_alu_cc.md
# pipelined_alu_cc

Parametrised, registered successor to the 64-bit combinational ALU for the pipelined Y86 execute stage. It has one result register behind a valid/ready handshake and an architectural condition-code register (ZF/SF/OF) updated on request. It also evaluates the Y86 branch/cmov condition against the current flags, and a flush input squashes the stage on misprediction. It sits between the decode/execute pipeline register and the memory stage.

## Interface
- `WIDTH`, 64: operand/result width in bits, ≥ 2.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: upstream offers an operation.
- `in_ready` out 1: stage can accept.
- `in_a` in WIDTH: operand A.
- `in_b` in WIDTH: operand B.
- `in_op` in 2: 00 ADD, 01 SUB (A−B), 10 XOR, 11 AND.
- `in_set_cc` in 1: this operation writes the condition codes.
- `in_cond` in 3: condition to evaluate: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 never.
- `flush` in 1: squash the held result and the incoming operation.
- `out_valid` out 1: result register holds a live operation.
- `out_ready` in 1: downstream accepts.
- `out_result` out WIDTH: registered result.
- `out_of` out 1: registered signed overflow of this operation.
- `out_cnd` out 1: registered condition outcome.
- `cc_zf`, `cc_sf`, `cc_of` out 1 each: current architectural flags.

## Operation
- Accept: `in_valid && in_ready && !flush`. Set `in_ready = !out_valid || out_ready`, independent of `in_valid`.
- On accept, capture `result`, `of` and `cnd` into the output register and set `out_valid`.
- Arithmetic is modulo 2^WIDTH; the carry is discarded.
  - ADD overflow: `a[MSB]==b[MSB] && r[MSB]!=a[MSB]`.
  - SUB computes `a − b` as `a + ~b + 1`. Overflow: `a[MSB]!=b[MSB] && r[MSB]!=a[MSB]`.
  - XOR and AND: overflow is 0.
- Condition codes:
  - On accept with `in_set_cc`: ZF = (r==0), SF = r[MSB], OF = computed overflow.
  - Without `in_set_cc`, the flags hold.
- Condition evaluation uses the flags *before* this operation's update:
  - le = (SF^OF)|ZF
  - l = SF^OF
  - e = ZF
  - ne = !ZF
  - ge = !(SF^OF)
  - g = !(SF^OF) & !ZF
  - always = 1, never = 0.
- Output drain: `out_valid && out_ready` with no accept in the same cycle clears `out_valid`. The data registers hold their last values.
- Flush has priority over everything:
  - clears `out_valid`;
  - drops any offered input, which is not accepted and writes no CC;
  - leaves the CC register unchanged.
- Simultaneous drain and accept: the register is overwritten with the new operation and `out_valid` stays 1.
- Stall (`out_valid && !out_ready`): output fields are held stable, `in_ready=0`, no CC update.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 operation per cycle while `out_ready=1`.
- Flags visible on `cc_*` the cycle after the setting accept.
- A back-to-back dependent condition sees the previous operation's flags.
- Reset values: `out_valid=0`, `out_result=0`, `out_of=0`, `out_cnd=0`, ZF=1, SF=0, OF=0.
- `in_ready=1` out of reset.
- Reset mid-stall discards the held operation.
- No combinational path from `in_*` to `out_*`.
- `in_ready` depends combinationally only on `out_valid` and `out_ready`.

## Structure
- Shared package `y86_alu_pkg`:
  - op enum (ADD/SUB/XOR/AND);
  - cond enum (ALWAYS..NEVER);
  - `cc_t` struct {zf, sf, of};
  - CC reset constant `CC_RESET = {1,0,0}`.
- Sub-module `alu_cond_eval`: combinational `cc_t` × cond → cnd. Reused later by the branch-prediction check.
- Datapath, handshake and CC register live in `pipelined_alu_cc`.

## Test plan
1. **ADD overflow**
   - Stimulus: ADD `a=0x7FFF_FFFF_FFFF_FFFF`, `b=1`, set_cc.
   - Required: result `0x8000_0000_0000_0000`, `out_of=1`; next cycle ZF=0, SF=1, OF=1.
2. **SUB to zero, then condition**
   - Stimulus: SUB `a=5`, `b=5`, set_cc; then cond=e with set_cc=0.
   - Required: result 0, ZF=1; second operation `out_cnd=1`, flags unchanged.
3. **Stall hold**
   - Stimulus: `out_ready=0` for 3 cycles after an XOR `0xF0^0xFF`.
   - Required: `out_result=0x0F` held, `in_ready=0`, second offered operation not accepted; with `out_ready=1`, that operation appears the cycle after it is accepted.
4. **Flush**
   - Stimulus: assert `flush` while holding a valid result and offering ADD with set_cc.
   - Required: `out_valid=0` next cycle, CC unchanged, the ADD never appears.
5. **Full-throughput stream**
   - Stimulus: 8 ADDs streamed with `out_ready=1`.
   - Required: 8 results on consecutive cycles; a cond=g operation following `SUB a=3,b=7` (set_cc) yields `out_cnd=0`.
6. **Async reset mid-operation**
   - Stimulus: assert `rst` mid-cycle while valid.
   - Required: outputs go immediately to reset values; ZF=1.
